// File: rtl/mem_stage_pkg.sv
// Shared types and bus tag encoding for the memory-stage access unit.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RMW   = 2'd3
    } mem_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_ADDR,
        ST_REQ_DATA,
        ST_WAIT_RESP,
        ST_HOLD
    } state_t;

    // Tag header fields, most-significant first: {op, MEMORY, DATA}.
    localparam logic       TAG_READ   = 1'b1;
    localparam logic       TAG_WRITE  = 1'b0;
    localparam logic [3:0] TAG_MEMORY = 4'b0001;
    localparam logic       TAG_DATA   = 1'b1;
    localparam int         TAG_HDR_W  = 6;

    // Header bits of reqtag; the top pads the remaining low bits with zeros.
    function automatic logic [TAG_HDR_W-1:0] mk_reqtag(input logic is_write);
        return {(is_write ? TAG_WRITE : TAG_READ), TAG_MEMORY, TAG_DATA};
    endfunction

endpackage

// File: rtl/mem_beat_serdes.sv
// Beat counter plus serialiser (wdata -> bus beats, MS beat first) and
// deserialiser (response beats -> DATA_W word, MS beat first).
module mem_beat_serdes #(
    parameter int BUS_W = 64,
    parameter int BEATS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [BEATS*BUS_W-1:0]   wdata,
    input  logic                     tx_adv,
    input  logic                     rx_shift,
    input  logic                     rx_clr,
    input  logic [BUS_W-1:0]         resp,
    output logic [BUS_W-1:0]         tx_beat,
    output logic [BEATS*BUS_W-1:0]   rx_data,
    output logic                     last_beat
);
    localparam int DATA_W = BEATS * BUS_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;

    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign tx_beat   = tx_q[DATA_W-1 -: BUS_W];
    assign rx_data   = rx_q;

    // Beat counter: wraps after the last beat so every phase starts at zero.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with <= so all registers sample pre-edge values.
        if (reset)                   cnt <= '0;
        else if (load)               cnt <= '0;
        else if (tx_adv || rx_shift) cnt <= last_beat ? '0 : cnt + 1'b1;
    end

    // Outgoing data shifts left so the current beat is always the top BUS_W bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       tx_q <= '0;
        else if (load)   tx_q <= wdata;
        else if (tx_adv) tx_q <= tx_q << BUS_W;
    end

    // Incoming beats enter at the bottom, so the first beat ends up most significant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         rx_q <= '0;
        else if (rx_clr)   rx_q <= '0;
        else if (rx_shift) rx_q <= (rx_q << BUS_W) | DATA_W'(resp);
    end

endmodule

// File: rtl/mem_stage_access_unit.sv
// Memory-stage engine: issues READ / WRITE / RMW accesses on the D-cache
// core bus, stalls the pipeline while busy and holds the result for writeback.
// Optional build macro MEM_STAGE_TIMEOUT_EN adds a response timeout.
module mem_stage_access_unit
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int BUS_W          = 64,
    parameter int BEATS          = 1,
    parameter int TAG_W          = 13,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [1:0]             in_op,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [BEATS*BUS_W-1:0] in_wdata,
    input  logic                   wb_stall,
    output logic                   stall_out,
    output logic                   done_out,
    output logic [BEATS*BUS_W-1:0] rdata_out,
    output logic                   err_out,
    output logic                   reqcyc,
    output logic [BUS_W-1:0]       req,
    output logic [TAG_W-1:0]       reqtag,
    input  logic                   reqack,
    input  logic                   respcyc,
    input  logic [BUS_W-1:0]       resp,
    output logic                   respack
);
    localparam int PAD_W = TAG_W - TAG_HDR_W;

    if (PAD_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mem_stage_access_unit: TAG_W must exceed the tag header, TIMEOUT_CYCLES must be positive");
    end

    state_t            state, state_nxt;
    mem_op_t           op_in, op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_phase;
    logic              accept, is_wr, tmo_hit;
    logic [BUS_W-1:0]  tx_beat;
    logic              last_beat;

    assign op_in  = mem_op_t'(in_op);
    assign accept = (state == ST_IDLE) && in_valid && !wb_stall && (op_in != OP_NONE);
    // RMW reuses the WRITE path once its read phase has captured the old data.
    assign is_wr  = (op_q == OP_WRITE) || wr_phase;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign tmo_hit = (state == ST_WAIT_RESP) && !respcyc && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
    assign err_out = err_q;

    // Idle-response counter: restarts on WAIT_RESP entry and on every response beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  tmo_cnt <= '0;
        else if (state != ST_WAIT_RESP || respcyc)  tmo_cnt <= '0;
        else                                        tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Error flag lives for exactly one HOLD episode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                err_q <= 1'b0;
        else if (tmo_hit)                         err_q <= 1'b1;
        else if (state == ST_HOLD && !wb_stall)   err_q <= 1'b0;
    end
`else
    assign tmo_hit = 1'b0;
    assign err_out = 1'b0;
`endif

    mem_beat_serdes #(
        .BUS_W (BUS_W),
        .BEATS (BEATS)
    ) u_serdes (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .wdata     (in_wdata),
        .tx_adv    ((state == ST_REQ_DATA) && reqack),
        .rx_shift  ((state == ST_WAIT_RESP) && respcyc && !is_wr),
        .rx_clr    (tmo_hit),
        .resp      (resp),
        .tx_beat   (tx_beat),
        .rx_data   (rdata_out),
        .last_beat (last_beat)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Access context captured at accept; wr_phase marks the RMW write half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_NONE;
            addr_q   <= '0;
            wr_phase <= 1'b0;
        end else if (accept) begin
            op_q     <= op_in;
            addr_q   <= in_addr;
            wr_phase <= 1'b0;
        end else if (state == ST_WAIT_RESP && op_q == OP_RMW && !wr_phase && respcyc && last_beat) begin
            wr_phase <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (accept) state_nxt = ST_REQ_ADDR;
            ST_REQ_ADDR:  if (reqack) state_nxt = is_wr ? ST_REQ_DATA : ST_WAIT_RESP;
            ST_REQ_DATA:  if (reqack && last_beat) state_nxt = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (respcyc) begin
                    if (is_wr)          state_nxt = ST_HOLD;
                    else if (last_beat) state_nxt = (op_q == OP_RMW) ? ST_REQ_ADDR : ST_HOLD;
                end else if (tmo_hit) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD:      if (!wb_stall) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Bus and pipeline handshake outputs, decoded from the current state.
    always_comb begin
        reqcyc    = 1'b0;
        req       = '0;
        reqtag    = '0;
        respack   = 1'b0;
        done_out  = 1'b0;
        stall_out = 1'b0;
        unique case (state)
            ST_IDLE: begin
                stall_out = accept;
                done_out  = in_valid && !wb_stall && (op_in == OP_NONE);
            end
            ST_REQ_ADDR: begin
                reqcyc    = 1'b1;
                req       = BUS_W'(addr_q);
                reqtag    = {mk_reqtag(is_wr), {PAD_W{1'b0}}};
                stall_out = 1'b1;
            end
            ST_REQ_DATA: begin
                reqcyc    = 1'b1;
                req       = tx_beat;
                reqtag    = {mk_reqtag(is_wr), {PAD_W{1'b0}}};
                stall_out = 1'b1;
            end
            ST_WAIT_RESP: begin
                respack   = respcyc;
                stall_out = 1'b1;
            end
            ST_HOLD: begin
                done_out  = !wb_stall;
                stall_out = wb_stall;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench: unit A (BUS_W=64, BEATS=1, TIMEOUT_CYCLES=8) covers read,
// RMW, writeback stall, reset and timeout; unit B (BUS_W=32, BEATS=2) covers
// the multi-beat write with a slow reqack.
module tb_mem_stage_access_unit;

    localparam logic [1:0]  OPC_NONE  = 2'd0;
    localparam logic [1:0]  OPC_READ  = 2'd1;
    localparam logic [1:0]  OPC_WRITE = 2'd2;
    localparam logic [1:0]  OPC_RMW   = 2'd3;
    // {op(1=read), MEMORY=0001, DATA=1, 7'b0}
    localparam logic [12:0] TAG_RD = 13'h1180;
    localparam logic [12:0] TAG_WR = 13'h0180;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_in_valid, a_wb_stall, a_stall, a_done, a_err;
    logic        a_reqcyc, a_reqack, a_respcyc, a_respack;
    logic [1:0]  a_in_op;
    logic [63:0] a_in_addr, a_in_wdata, a_rdata, a_req, a_resp;
    logic [12:0] a_reqtag;

    logic        b_in_valid, b_wb_stall, b_stall, b_done, b_err;
    logic        b_reqcyc, b_reqack, b_respcyc, b_respack;
    logic [1:0]  b_in_op;
    logic [63:0] b_in_addr, b_in_wdata, b_rdata;
    logic [31:0] b_req, b_resp;
    logic [12:0] b_reqtag;

    mem_stage_access_unit #(
        .ADDR_W(64), .BUS_W(64), .BEATS(1), .TAG_W(13), .TIMEOUT_CYCLES(8)
    ) u_dut_a (
        .clk(clk), .reset(rst), .in_valid(a_in_valid), .in_op(a_in_op),
        .in_addr(a_in_addr), .in_wdata(a_in_wdata), .wb_stall(a_wb_stall),
        .stall_out(a_stall), .done_out(a_done), .rdata_out(a_rdata), .err_out(a_err),
        .reqcyc(a_reqcyc), .req(a_req), .reqtag(a_reqtag), .reqack(a_reqack),
        .respcyc(a_respcyc), .resp(a_resp), .respack(a_respack)
    );

    mem_stage_access_unit #(
        .ADDR_W(64), .BUS_W(32), .BEATS(2), .TAG_W(13), .TIMEOUT_CYCLES(8)
    ) u_dut_b (
        .clk(clk), .reset(rst), .in_valid(b_in_valid), .in_op(b_in_op),
        .in_addr(b_in_addr), .in_wdata(b_in_wdata), .wb_stall(b_wb_stall),
        .stall_out(b_stall), .done_out(b_done), .rdata_out(b_rdata), .err_out(b_err),
        .reqcyc(b_reqcyc), .req(b_req), .reqtag(b_reqtag), .reqack(b_reqack),
        .respcyc(b_respcyc), .resp(b_resp), .respack(b_respack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled mid-cycle.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_quiet();
        a_in_valid = 1'b0; a_in_op = OPC_NONE; a_wb_stall = 1'b0;
        a_reqack = 1'b0; a_respcyc = 1'b0; a_resp = '0;
    endtask

    task automatic a_issue(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] wdata);
        a_in_valid = 1'b1; a_in_op = op; a_in_addr = addr; a_in_wdata = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    logic [31:0] b_beats [3];

    initial begin
        rst = 1'b1;
        a_quiet(); a_in_addr = '0; a_in_wdata = '0;
        b_in_valid = 1'b0; b_in_op = OPC_NONE; b_in_addr = '0; b_in_wdata = '0;
        b_wb_stall = 1'b0; b_reqack = 1'b0; b_respcyc = 1'b0; b_resp = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_reqcyc", a_reqcyc, 0);
        check("rst_stall",  a_stall,  0);
        check("rst_done",   a_done,   0);
        check("rst_err",    a_err,    0);
        check("rst_rdata",  a_rdata,  0);
        check("rst_req",    a_req,    0);
        check("rst_reqtag", a_reqtag, 0);
        check("rst_b_reqcyc", b_reqcyc, 0);
        rst = 1'b0;
        cyc();

        // Single READ, zero-wait bus.
        a_issue(OPC_READ, 64'h1000, 64'h0);
        #1 check("rd_c0_stall", a_stall, 1);
        check("rd_c0_reqcyc", a_reqcyc, 0);
        cyc(); a_in_valid = 1'b0; a_reqack = 1'b1;
        #1 check("rd_c1_reqcyc", a_reqcyc, 1);
        check("rd_c1_req", a_req, 64'h1000);
        check("rd_c1_tag", a_reqtag, TAG_RD);
        check("rd_c1_stall", a_stall, 1);
        cyc(); a_reqack = 1'b0; a_respcyc = 1'b1; a_resp = 64'hDEADBEEF;
        #1 check("rd_c2_respack", a_respack, 1);
        check("rd_c2_stall", a_stall, 1);
        check("rd_c2_done", a_done, 0);
        check("rd_c2_reqcyc", a_reqcyc, 0);
        cyc(); a_respcyc = 1'b0;
        #1 check("rd_c3_done", a_done, 1);
        check("rd_c3_rdata", a_rdata, 64'hDEADBEEF);
        check("rd_c3_stall", a_stall, 0);
        cyc();
        #1 check("rd_c4_done", a_done, 0);

        // Stray response outside WAIT_RESP is not acknowledged.
        a_respcyc = 1'b1;
        #1 check("idle_respack", a_respack, 0);
        a_respcyc = 1'b0;

        // NONE passes straight through in the same cycle.
        a_in_valid = 1'b1; a_in_op = OPC_NONE;
        #1 check("none_done", a_done, 1);
        check("none_stall", a_stall, 0);
        a_wb_stall = 1'b1;
        #1 check("none_wbstall_done", a_done, 0);
        a_quiet();
        cyc();
        #1 check("none_no_req", a_reqcyc, 0);

        // RMW exchange with a writeback stall in HOLD.
        a_issue(OPC_RMW, 64'h40, 64'h5);
        cyc(); a_in_valid = 1'b0; a_reqack = 1'b1;
        #1 check("rmw_rd_req", a_req, 64'h40);
        check("rmw_rd_tag", a_reqtag, TAG_RD);
        cyc(); a_reqack = 1'b0; a_respcyc = 1'b1; a_resp = 64'h9;
        #1 check("rmw_rd_respack", a_respack, 1);
        cyc(); a_respcyc = 1'b0; a_reqack = 1'b1;
        #1 check("rmw_wr_reqcyc", a_reqcyc, 1);
        check("rmw_wr_addr", a_req, 64'h40);
        check("rmw_wr_tag", a_reqtag, TAG_WR);
        cyc();
        #1 check("rmw_wr_data", a_req, 64'h5);
        check("rmw_wr_dtag", a_reqtag, TAG_WR);
        cyc(); a_reqack = 1'b0; a_respcyc = 1'b1; a_resp = '0; a_wb_stall = 1'b1;
        #1 check("rmw_wr_respack", a_respack, 1);
        cyc(); a_respcyc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("hold_stall%0d_done", i), a_done, 0);
            check($sformatf("hold_stall%0d_stall", i), a_stall, 1);
            check($sformatf("hold_stall%0d_rdata", i), a_rdata, 64'h9);
            cyc();
        end
        a_wb_stall = 1'b0;
        #1 check("hold_rel_done", a_done, 1);
        check("hold_rel_rdata", a_rdata, 64'h9);
        check("hold_rel_stall", a_stall, 0);
        cyc();
        #1 check("hold_after_done", a_done, 0);

        // Two-beat WRITE on unit B, reqack held off two cycles per beat.
        b_beats[0] = 32'h0000_1000;
        b_beats[1] = 32'h1111_2222;
        b_beats[2] = 32'h3333_4444;
        b_in_valid = 1'b1; b_in_op = OPC_WRITE; b_in_addr = 64'h1000;
        b_in_wdata = 64'h1111_2222_3333_4444;
        cyc(); b_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 3; w++) begin
                b_reqack = (w == 2);
                #1 check($sformatf("wr_beat%0d_w%0d_req", i, w), b_req, b_beats[i]);
                check($sformatf("wr_beat%0d_w%0d_reqcyc", i, w), b_reqcyc, 1);
                check($sformatf("wr_beat%0d_w%0d_tag", i, w), b_reqtag, TAG_WR);
                cyc();
            end
        end
        b_reqack = 1'b0; b_respcyc = 1'b1;
        #1 check("wr_respack", b_respack, 1);
        check("wr_resp_done", b_done, 0);
        check("wr_resp_reqcyc", b_reqcyc, 0);
        cyc(); b_respcyc = 1'b0;
        #1 check("wr_done", b_done, 1);
        check("wr_err", b_err, 0);
        cyc();
        #1 check("wr_after_done", b_done, 0);

        // Reset while sending the data beat of a WRITE.
        a_issue(OPC_WRITE, 64'h80, 64'h77);
        cyc(); a_in_valid = 1'b0; a_reqack = 1'b1;
        cyc(); a_reqack = 1'b0;
        #1 check("rstmid_reqcyc_before", a_reqcyc, 1);
        check("rstmid_req_before", a_req, 64'h77);
        #1 rst = 1'b1;
        #1 check("rstmid_reqcyc", a_reqcyc, 0);
        check("rstmid_stall", a_stall, 0);
        check("rstmid_req", a_req, 0);
        check("rstmid_reqtag", a_reqtag, 0);
        check("rstmid_rdata", a_rdata, 0);
        check("rstmid_done", a_done, 0);
        @(negedge clk);
        rst = 1'b0;
        a_issue(OPC_READ, 64'h2000, 64'h0);
        cyc(); a_in_valid = 1'b0; a_reqack = 1'b1;
        #1 check("rstrd_req", a_req, 64'h2000);
        cyc(); a_reqack = 1'b0; a_respcyc = 1'b1; a_resp = 64'h0123_4567_89AB_CDEF;
        cyc(); a_respcyc = 1'b0;
        #1 check("rstrd_done", a_done, 1);
        check("rstrd_rdata", a_rdata, 64'h0123_4567_89AB_CDEF);
        cyc();

`ifdef MEM_STAGE_TIMEOUT_EN
        // No response at all: HOLD with error nine cycles after WAIT_RESP entry.
        a_issue(OPC_READ, 64'h3000, 64'h0);
        cyc(); a_in_valid = 1'b0; a_reqack = 1'b1;
        cyc(); a_reqack = 1'b0;
        repeat (8) cyc();
        #1 check("tmo_c8_done", a_done, 0);
        check("tmo_c8_stall", a_stall, 1);
        cyc();
        #1 check("tmo_done", a_done, 1);
        check("tmo_err", a_err, 1);
        check("tmo_rdata", a_rdata, 0);
        cyc();
        #1 check("tmo_after_err", a_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
